// File: rtl/basic_logic_calculator.sv
// basic_logic_calculator: single-bit logic unit selecting AND, OR, NOT A or
// NOT B under a 2-bit opcode. Result is combinational. A registered copy and
// a saturating count of high-result edges are kept for downstream stages.
module basic_logic_calculator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic [1:0]       S,
  output logic             Result,
  output logic             result_q,
  output logic [CNT_W-1:0] hi_count
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_NOTA = 2'b10,
    OP_NOTB = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Opcode decode; Result depends only on A, B and S, never on clk or rst.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred even if an opcode arm is later removed.
    Result = 1'b0;
    case (op_e'(S))
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_NOTA: Result = ~A;
      OP_NOTB: Result = ~B;
      default: Result = 1'b0;
    endcase
  end

  // One-cycle registered copy of Result; reset takes priority.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (rst) begin
      result_q <= 1'b0;
    end else begin
      result_q <= Result;
    end
  end

  // Saturating count of edges at which Result was high; holds at CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_count <= '0;
    end else if (Result && (hi_count != CNT_MAX)) begin
      hi_count <= hi_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_basic_logic_calculator.sv
// Directed self-checking bench for basic_logic_calculator. A second instance
// with a 2-bit counter exercises saturation from the same stimulus.
module tb_basic_logic_calculator;

  logic       clk;
  logic       clk_run;
  logic       rst;
  logic       A;
  logic       B;
  logic [1:0] S;
  logic       Result;
  logic       result_q;
  logic [7:0] hi_count;
  logic       result_n2;
  logic       result_q_n2;
  logic [1:0] hi_count_n2;

  int total;
  int bad;

  basic_logic_calculator #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .S        (S),
    .Result   (Result),
    .result_q (result_q),
    .hi_count (hi_count)
  );

  basic_logic_calculator #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .S        (S),
    .Result   (result_n2),
    .result_q (result_q_n2),
    .hi_count (hi_count_n2)
  );

  // Free-running 10-unit clock that can be parked for the combinational sweep.
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    A = 1'b1; B = 1'b1; S = 2'b00;
    do_reset();
    total++;
    if (result_q !== 1'b0) begin
      bad++; $display("FAIL reset_result_q got=%b want=0", result_q);
    end
    total++;
    if (hi_count !== 8'd0) begin
      bad++; $display("FAIL reset_hi_count got=%0d want=0", hi_count);
    end
    total++;
    if (hi_count_n2 !== 2'd0) begin
      bad++; $display("FAIL reset_hi_count_w2 got=%0d want=0", hi_count_n2);
    end
  endtask

  // All 16 (S,A,B) combinations with the clock parked.
  task automatic test_comb_sweep();
    logic [3:0] exp_tbl [4];
    logic [3:0] row;
    exp_tbl[0] = 4'b1000;  // AND:   ab=11 only
    exp_tbl[1] = 4'b1110;  // OR:    all but ab=00
    exp_tbl[2] = 4'b0011;  // NOT A: ab=00,01
    exp_tbl[3] = 4'b0101;  // NOT B: ab=00,10
    clk_run = 1'b0;
    for (int s = 0; s < 4; s++) begin
      row = exp_tbl[s];
      for (int ab = 0; ab < 4; ab++) begin
        S = 2'(s);
        A = ab[1];
        B = ab[0];
        #10;
        total++;
        if (Result !== row[ab]) begin
          bad++;
          $display("FAIL comb S=%0d A=%b B=%b got=%b want=%b", s, A, B, Result, row[ab]);
        end
      end
    end
    clk_run = 1'b1;
  endtask

  task automatic test_registered();
    A = 1'b1; B = 1'b1; S = 2'b00;
    do_reset();
    tick();
    total++;
    if (result_q !== 1'b1) begin
      bad++; $display("FAIL reg_first got=%b want=1", result_q);
    end
    S = 2'b10;
    #1;
    total++;
    if (Result !== 1'b0) begin
      bad++; $display("FAIL reg_comb_now got=%b want=0", Result);
    end
    total++;
    if (result_q !== 1'b1) begin
      bad++; $display("FAIL reg_hold got=%b want=1", result_q);
    end
    tick();
    total++;
    if (result_q !== 1'b0) begin
      bad++; $display("FAIL reg_update got=%b want=0", result_q);
    end
  endtask

  task automatic test_counter();
    A = 1'b0; B = 1'b0; S = 2'b10;
    do_reset();
    repeat (5) tick();
    total++;
    if (hi_count !== 8'd5) begin
      bad++; $display("FAIL cnt_five got=%0d want=5", hi_count);
    end
    S = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (hi_count !== 8'd5) begin
        bad++; $display("FAIL cnt_hold edge=%0d got=%0d want=5", i, hi_count);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [6];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3; exp_sat[5] = 2'd3;
    A = 1'b0; B = 1'b0; S = 2'b10;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (hi_count_n2 !== exp_sat[i]) begin
        bad++; $display("FAIL sat_w2 edge=%0d got=%0d want=%0d", i, hi_count_n2, exp_sat[i]);
      end
    end
    total++;
    if (hi_count !== 8'd6) begin
      bad++; $display("FAIL sat_w8 got=%0d want=6", hi_count);
    end
  endtask

  task automatic test_reset_mid();
    A = 1'b0; B = 1'b0; S = 2'b10;
    do_reset();
    repeat (5) tick();
    total++;
    if (hi_count !== 8'd5 || result_q !== 1'b1) begin
      bad++; $display("FAIL mid_pre got cnt=%0d q=%b want cnt=5 q=1", hi_count, result_q);
    end
    rst = 1'b1;
    tick();
    total++;
    if (hi_count !== 8'd0 || result_q !== 1'b0 || Result !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst got cnt=%0d q=%b r=%b want cnt=0 q=0 r=1", hi_count, result_q, Result);
    end
    rst = 1'b0;
    tick();
    total++;
    if (hi_count !== 8'd1) begin
      bad++; $display("FAIL mid_resume got=%0d want=1", hi_count);
    end
  endtask

  task automatic test_reset_indep();
    logic [3:0] exp_r;
    exp_r = 4'b1010;  // S=0..3 with A=1,B=0 -> 0,1,0,1
    A = 1'b1; B = 1'b0;
    rst = 1'b1;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1;
      total++;
      if (Result !== exp_r[s]) begin
        bad++; $display("FAIL indep_result S=%0d got=%b want=%b", s, Result, exp_r[s]);
      end
      tick();
      total++;
      if (result_q !== 1'b0 || hi_count !== 8'd0) begin
        bad++; $display("FAIL indep_regs S=%0d got q=%b cnt=%0d want q=0 cnt=0", s, result_q, hi_count);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] vec   [5];  // {A,B,S}
    logic       exp_q [5];
    logic [7:0] exp_c [5];
    vec[0] = 4'b1001; exp_q[0] = 1'b1; exp_c[0] = 8'd1;  // 1 OR 0
    vec[1] = 4'b1000; exp_q[1] = 1'b0; exp_c[1] = 8'd1;  // 1 AND 0
    vec[2] = 4'b0111; exp_q[2] = 1'b0; exp_c[2] = 8'd1;  // NOT 1
    vec[3] = 4'b0011; exp_q[3] = 1'b1; exp_c[3] = 8'd2;  // NOT 0
    vec[4] = 4'b1100; exp_q[4] = 1'b1; exp_c[4] = 8'd3;  // 1 AND 1
    A = 1'b0; B = 1'b0; S = 2'b00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {A, B, S} = vec[i];
      tick();
      total++;
      if (result_q !== exp_q[i] || hi_count !== exp_c[i]) begin
        bad++;
        $display("FAIL b2b step=%0d got q=%b cnt=%0d want q=%b cnt=%0d",
                 i, result_q, hi_count, exp_q[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    clk_run = 1'b1;
    rst     = 1'b1;
    A       = 1'b0;
    B       = 1'b0;
    S       = 2'b00;
    test_reset();
    test_comb_sweep();
    test_registered();
    test_counter();
    test_saturation();
    test_reset_mid();
    test_reset_indep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/basic_logic_calculator.md
Name: basic_logic_calculator

Overview:
- 1-bit, 4-function logic unit: selects AND, OR, NOT A or NOT B of two single-bit operands under a 2-bit opcode.
- Primary output Result is purely combinational.
- A registered copy of Result and a saturating count of high-result cycles are provided for downstream pipeline stages and status monitoring.
- Leaf block; sits in datapath/control glue wherever a selectable single-bit logic function is needed.

Parameters:
- CNT_W, 8, width of the high-result cycle counter hi_count (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  1  operand A.
- B  input  1  operand B.
- S  input  2  opcode select.
- Result  output  1  combinational function result.
- result_q  output  1  Result registered on rising clk edge.
- hi_count  output  CNT_W  saturating count of rising edges at which Result was 1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Opcode map for Result (combinational, zero clock latency):
  - S=2'b00: A AND B.
  - S=2'b01: A OR B.
  - S=2'b10: NOT A (B ignored).
  - S=2'b11: NOT B (A ignored).
- Result is a clean 0/1 (never X/Z) whenever A, B and S are all known 0/1.
- Result must settle within the same simulation time step as any input change; no clock edge is required.
- Result is independent of clk and rst; reset does not force it.
- result_q:
  - On rising clk with rst=1: result_q <= 0.
  - Otherwise: result_q <= current Result; one-cycle latency.
- hi_count:
  - On rising clk with rst=1: cleared to 0.
  - Otherwise, increments by 1 when Result=1 at that edge.
  - Saturates at 2^CNT_W-1; never wraps.
  - Holds its value when Result=0.
- Reset mid-operation: the registered outputs clear on the next rising edge with rst=1. Result continues to track inputs during reset. Counting resumes on the first edge with rst=0.
- Simultaneous rst=1 and Result=1: reset wins; hi_count=0 and result_q=0.
- Power-up (before the first reset edge): registered outputs are undefined; consumers must apply reset.

Test Plan:
- Exhaustive combinational sweep: all 16 combinations of S, A, B, holding each 10 time units with no clock edge. Required Result per (A,B)=00,01,10,11:
  - S=00 -> 0,0,0,1.
  - S=01 -> 0,1,1,1.
  - S=10 -> 1,1,0,0.
  - S=11 -> 1,0,1,0.
  - Check with a 4-state compare (no X/Z).
- Registered path: after reset, apply A=1,B=1,S=00 then clock once -> result_q=1. Change to S=10 -> Result=0 immediately; result_q stays 1 until the next edge, then becomes 0.
- Counter: reset, then hold A=0,S=10 (Result=1) for 5 edges -> hi_count=5. Switch to S=00,A=0 for 3 edges -> hi_count stays 5.
- Saturation with CNT_W=2: hold Result=1 for 6 edges -> hi_count=3, remaining 3 with no wrap.
- Reset mid-operation: with hi_count=5 and result_q=1, assert rst for one edge while Result=1 -> hi_count=0, result_q=0, and Result still 1. Deassert rst -> next edge gives hi_count=1.
- Reset independence: with rst held high, sweep S from 00 to 11 with A=1,B=0 -> Result=0,1,0,1 while result_q and hi_count stay 0.
